alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the 8-bit combinational ALU, with a `WIDTH`-bit datapath. It adds a start/done handshake, registered result and flags, and a multi-cycle shift-add multiply. It sits between the register file and the write-back path of the CPU. The control FSM issues one operation per `start` pulse and waits on `done`.

## Interface
- `WIDTH`, 8, operand/result width (≥ 2)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: request; sampled on a rising edge when `busy` = 0
- `A` in WIDTH: operand A, sampled with `start`
- `B` in WIDTH: operand B, sampled with `start`
- `Op` in 3: opcode, sampled with `start`
- `Cin` in 1: carry in, used by ADD only
- `Y` out WIDTH: registered result, held until the next accepted op
- `Cout` out 1: registered carry / no-borrow / shifted-out bit / multiply overflow
- `Zero` out 1: registered, `Y` == 0
- `Neg` out 1: registered, `Y[WIDTH-1]`
- `Ovf` out 1: registered signed overflow (ADD/SUB only, else 0)
- `busy` out 1: multiply in progress; `start` is ignored while high
- `done` out 1: one-cycle pulse, result valid
- Reset: one clock; reset is synchronous and active-high. While `rst` = 1, all outputs are 0.

## Operation
- Opcodes:
  - 000 ADD: `A+B+Cin`; `Cout` = carry
  - 001 SUB: `A+~B+1`, `Cin` ignored; `Cout` = 1 when no borrow
  - 010 AND, 011 OR, 100 XOR, 101 NOT A: `Cout` = 0
  - 110 SHL1: `Y = A<<1`; `Cout = A[WIDTH-1]`
  - 111 MUL: unsigned; `Y` = low WIDTH bits of `A*B`; `Cout` = OR of the high WIDTH bits
- `Ovf`:
  - ADD: operands share a sign bit and the result sign differs.
  - SUB: operand signs differ and the result sign differs from `A`.
  - All other ops: 0.
- `Zero` and `Neg` are computed from the final `Y` for every op.
- FSM states:
  - IDLE: `start` with a non-MUL `Op` → write `Y`/flags, pulse `done`, stay in IDLE. `start` with MUL → load the multiplicand, multiplier and a 2·WIDTH accumulator, clear the counter, go to RUN.
  - RUN: each edge, if the multiplier LSB is set, add the multiplicand (shifted) into the accumulator, then shift. After the WIDTH-th iteration, write `Y`/flags, pulse `done`, return to IDLE.
- `busy` = 1 exactly while in RUN.
- `start` during RUN is ignored and is not queued.
- `Y` and the flags are unchanged until the next accepted op completes. They are not cleared at start.
- Reset mid-RUN aborts the multiply. No `done` is issued and outputs go to 0.

## Timing
- `start` high in cycle k (sampled at the end of cycle k).
- Non-MUL: `Y`, flags and `done` are valid in cycle k+1. `done` drops in k+2 unless a new op is accepted in cycle k+1.
- Back-to-back non-MUL starts are accepted every cycle. `done` stays high and `Y` updates each cycle.
- MUL:
  - `busy` is high in cycles k+1 … k+WIDTH.
  - `Y`, flags and `done` are valid in cycle k+WIDTH+1, with `busy` = 0 in that cycle.
  - A new `start` in cycle k+WIDTH+1 is accepted.
- No combinational path from inputs to outputs.

## Configuration
- Macro `ALU_SEQ_MUL_EN`.
- Defined: Op 111 = MUL as above, RUN state present.
- Undefined:
  - Op 111 = SHR1, single-cycle: `Y = A>>1`, `Cout = A[0]`.
  - No RUN state; `busy` is tied to 0.
  - Every op has latency 1.

## Structure
- Package `alu_pkg`: opcode constants (`OP_ADD` … `OP_MUL`) and the FSM state type (IDLE, RUN).
- Sub-module `alu_seq_mul`: shift-add multiplier core (load, step, count, result). Instantiated only under `ALU_SEQ_MUL_EN`.
- The single-cycle ops stay inline in `alu_seq`.

## Test plan
- WIDTH=8, ADD 7+8, `Cin`=0 → cycle k+1: `Y`=15, `Cout`=0, `Zero`=0, `done`=1; `done`=0 in k+2.
- ADD 200+100 → `Y`=44, `Cout`=1, `Ovf`=0. ADD 100+100 → `Y`=200, `Neg`=1, `Ovf`=1. SUB 5−5 → `Y`=0, `Zero`=1, `Cout`=1.
- MUL 12×11 → `busy` high for 8 cycles, `done` in k+9, `Y`=132, `Cout`=0. MUL 16×16 → `Y`=0, `Cout`=1, `Zero`=1.
- MUL 3×3 with `start` for ADD 1+1 pulsed in cycle k+3 → ADD ignored; only one `done`, `Y`=9. Then ADD 1+1 in the done cycle → `Y`=2 one cycle later.
- `rst` asserted in cycle k+4 of a MUL → all outputs 0 from the next cycle, no `done`, `start` accepted immediately after `rst` drops.
- WIDTH=16, ADD 0xFFFF+1 → `Y`=0, `Cout`=1, `Zero`=1. With `ALU_SEQ_MUL_EN` undefined, Op 111 on A=0x0003 → `Y`=1, `Cout`=1, `busy` never high.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pkg : opcode constants and control-state type shared by alu_seq
// Rev 1.0
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  // Same code is SHR1 when the multiplier is not built.
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_seq_mul : shift-add unsigned multiplier core, one partial product per step
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int c_cnt_w = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_cnt_w-1:0] r_cnt;

  // Accumulator after the current step; it is the full product when last is high.
  assign product = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign last    = (r_cnt == c_cnt_w'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= '0;
    end else if (step) begin
      r_acc    <= product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_seq : registered WIDTH-bit ALU with start/done handshake.
// Optional multi-cycle MUL on Op 111 when ALU_SEQ_MUL_EN is defined (else SHR1).
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             Cin,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_y;
  logic             w_cout;
  logic             w_ovf;

  always_comb begin
    w_sum  = '0;
    w_y    = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (Op)
      OP_ADD: begin
        w_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
        w_y    = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        w_y    = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: w_y = A & B;
      OP_OR:  w_y = A | B;
      OP_XOR: w_y = A ^ B;
      OP_NOT: w_y = ~A;
      OP_SHL: begin
        w_y    = {A[WIDTH-2:0], 1'b0};
        w_cout = A[WIDTH-1];
      end
      OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
        w_y    = {1'b0, A[WIDTH-1:1]};
        w_cout = A[0];
`endif
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  state_t             r_state;
  logic               w_load;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod;

  assign w_load = (r_state == IDLE) && start && (Op == OP_MUL);

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .step   (r_state == RUN),
    .a      (A),
    .b      (B),
    .last   (w_last),
    .product(w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      Y       <= '0;
      Cout    <= 1'b0;
      Zero    <= 1'b0;
      Neg     <= 1'b0;
      Ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (Op == OP_MUL)) begin
            r_state <= RUN;
            busy    <= 1'b1;
          end else if (start) begin
            Y    <= w_y;
            Cout <= w_cout;
            Zero <= (w_y == '0);
            Neg  <= w_y[WIDTH-1];
            Ovf  <= w_ovf;
            done <= 1'b1;
          end
        end
        RUN: begin
          // Result is taken straight from the final step, saving a cycle.
          if (w_last) begin
            Y       <= w_prod[WIDTH-1:0];
            Cout    <= |w_prod[2*WIDTH-1:WIDTH];
            Zero    <= (w_prod[WIDTH-1:0] == '0);
            Neg     <= w_prod[WIDTH-1];
            Ovf     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      Y    <= '0;
      Cout <= 1'b0;
      Zero <= 1'b0;
      Neg  <= 1'b0;
      Ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        Y    <= w_y;
        Cout <= w_cout;
        Zero <= (w_y == '0);
        Neg  <= w_y[WIDTH-1];
        Ovf  <= w_ovf;
      end
    end
  end
`endif

endmodule
`default_nettype wire
